// File: rtl/fifo_uart_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_pkg
// Shared definitions for the 256x8 UART FIFO path (write and read controllers).
//   - Default byte width and settle-delay length for the read controller.
//   - One-hot state constants for the read-side drain FSM.
// ---------------------------------------------------------------------------
package fifo_uart_pkg;

    // Default FIFO/UART byte width.
    localparam int DATA_W_DEF  = 8;

    // Default settle-delay length before the first pop (legal range 1..15).
    localparam int DLY_CYC_DEF = 10;

    // Read-controller state vector type (one-hot, six states).
    typedef logic [5:0] rd_state_t;

    // One-hot state constants, kept as plain vectors so that older tools and
    // the write controller can share them without enum casting.
    localparam logic [5:0] ST_IDLE     = 6'b000001;
    localparam logic [5:0] ST_WAIT_DLY = 6'b000010;
    localparam logic [5:0] ST_RD_CHK   = 6'b000100;
    localparam logic [5:0] ST_RD_REQ   = 6'b001000;
    localparam logic [5:0] ST_RD_CAP   = 6'b010000;
    localparam logic [5:0] ST_TX_WAIT  = 6'b100000;

endpackage : fifo_uart_pkg

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// One-bit, two-flop synchronizer with asynchronous active-low reset.
// Both flops reset to 0. Shared by the FIFO read and write controllers.
// Ports:
//   clk_i    in   destination-domain clock
//   rst_n_i  in   asynchronous active-low reset
//   d_i      in   asynchronous input bit
//   q_o      out  synchronized bit (second flop)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller of the 256x8 UART FIFO path. After the FIFO reports
// almost-full it waits a settle delay, then drains the FIFO one byte at a
// time: pop, hand the byte to the UART with a start pulse, wait for the UART
// to go idle, repeat. When the FIFO is empty it pulses fifo_rd_ok and idles.
//
// Build option:
//   FIFO_RD_AF_SYNC_EN  defined   -> almost_full passes through sync_2ff
//                                    (asynchronous write/read clocks)
//                       undefined -> almost_full used directly (common clock)
//
// Ports:
//   sys_clk       in   system clock (FIFO read port and UART clock)
//   sys_rst_n     in   asynchronous active-low reset
//   almost_full   in   FIFO almost-full flag (write-clock domain)
//   empty         in   FIFO empty flag (read-clock domain)
//   fifo_rd_data  in   FIFO output data, valid the cycle after a pop
//   tx_busy       in   UART transmitter busy
//   fifo_rd_en    out  registered one-cycle FIFO read enable per byte
//   tx_data       out  registered byte for the UART, held until next capture
//   tx_start      out  one-cycle transmit start pulse
//   fifo_rd_ok    out  one-cycle pulse when the drain completes
// ---------------------------------------------------------------------------
module fifo_rd_ctrl
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DLY_CYC = DLY_CYC_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              almost_full,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              tx_busy,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    output logic              fifo_rd_ok
);

    localparam logic [3:0] DLY_LIM = 4'(DLY_CYC);

    logic              af_s;

    rd_state_t         state_q,    state_d;
    logic [3:0]        dly_cnt_q,  dly_cnt_d;
    logic              first_q,    first_d;
    logic              rd_en_q,    rd_en_d;
    logic [DATA_W-1:0] tx_data_q,  tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              rd_ok_q,    rd_ok_d;

`ifdef FIFO_RD_AF_SYNC_EN
    // almost_full comes from the write clock domain; retime it before use.
    sync_2ff u_af_sync (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n),
        .d_i     (almost_full),
        .q_o     (af_s)
    );
`else
    assign af_s = almost_full;
`endif

    // Next-state logic. The three pulse outputs default to 0 so each is high
    // for exactly the one cycle following the state that sets it; this is
    // also what drops tx_start on the first TX_WAIT cycle.
    always_comb begin
        state_d    = state_q;
        dly_cnt_d  = dly_cnt_q;
        first_d    = first_q;
        rd_en_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        rd_ok_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (af_s) begin
                    state_d = ST_WAIT_DLY;
                end
            end

            // Counts 0..DLY_CYC inclusive, giving DLY_CYC+1 settle edges.
            ST_WAIT_DLY: begin
                if (dly_cnt_q == DLY_LIM) begin
                    dly_cnt_d = 4'd0;
                    state_d   = ST_RD_CHK;
                end else begin
                    dly_cnt_d = dly_cnt_q + 4'd1;
                end
            end

            // The only place empty is looked at, so a pop never hits an
            // empty FIFO. almost_full is deliberately not re-checked.
            ST_RD_CHK: begin
                if (empty) begin
                    rd_ok_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    rd_en_d = 1'b1;
                    state_d = ST_RD_REQ;
                end
            end

            // FIFO pops on this edge; data is valid during the next cycle.
            ST_RD_REQ: begin
                state_d = ST_RD_CAP;
            end

            ST_RD_CAP: begin
                tx_data_d  = fifo_rd_data;
                tx_start_d = 1'b1;
                first_d    = 1'b1;
                state_d    = ST_TX_WAIT;
            end

            // The UART may not have raised tx_busy yet on the first cycle,
            // so that cycle ignores it.
            ST_TX_WAIT: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!tx_busy) begin
                    state_d = ST_RD_CHK;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                dly_cnt_d = 4'd0;
                first_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately,
    // including a drain or a pulse in progress.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            dly_cnt_q  <= 4'd0;
            first_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            rd_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_cnt_q  <= dly_cnt_d;
            first_q    <= first_d;
            rd_en_q    <= rd_en_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            rd_ok_q    <= rd_ok_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign fifo_rd_ok = rd_ok_q;

endmodule : fifo_rd_ctrl
